// File: rtl/sec_arb_pkg.sv
// Shared types for the security channel arbiter: request ops, response error
// codes and the arbiter FSM state encoding.
package sec_arb_pkg;

  typedef enum logic [1:0] {
    OP_HASH = 2'b00,
    OP_ENC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_AUTH    = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_OP      = 2'b11
  } err_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with
// wrap-around. Reusable by any multi-channel block.
module rr_arbiter #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic                      found,
  output logic [$clog2(NUM_CH)-1:0] grant
);

  localparam int IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest offset down so the nearest request to ptr wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_CH);
      if (req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

endmodule

// File: rtl/sec_channel_arbiter.sv
// Round-robin front end sharing one crypto engine port between NUM_CH
// requesters, with PCM auth gating, engine timeout and tagged error responses.
module sec_channel_arbiter
  import sec_arb_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 128,
  parameter int TIMEOUT_CYC = 1024,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_auth,
  input  logic [NUM_CH-1:0]          ch_req_valid,
  output logic [NUM_CH-1:0]          ch_req_ready,
  input  logic [2*NUM_CH-1:0]        ch_req_op,
  input  logic [DATA_W*NUM_CH-1:0]   ch_req_data,
  output logic [NUM_CH-1:0]          ch_rsp_valid,
  output logic [DATA_W-1:0]          ch_rsp_data,
  output logic [1:0]                 ch_rsp_err,
  output logic                       eng_req_valid,
  input  logic                       eng_req_ready,
  output logic [1:0]                 eng_op,
  output logic [DATA_W-1:0]          eng_data,
  input  logic                       eng_rsp_valid,
  input  logic [DATA_W-1:0]          eng_rsp_data,
  output logic                       eng_abort,
  output logic                       busy,
  output logic [$clog2(NUM_CH)-1:0]  grant_id,
  output logic [CNT_W-1:0]           err_count
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

  state_e            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  win_idx;
  logic              found;
  op_e               win_op;
  op_e               op_q;
  logic [DATA_W-1:0] win_data;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rsp_q;
  err_e              err_q;
  logic [TMR_W-1:0]  timer;
  logic              win_auth;
  logic              accept;
  logic              timed_out;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req   (ch_req_valid),
    .ptr   (rr_ptr),
    .found (found),
    .grant (win_idx)
  );

  always_comb begin
    win_op   = op_e'(ch_req_op[2*win_idx +: 2]);
    win_data = ch_req_data[win_idx*DATA_W +: DATA_W];
    win_auth = ch_auth[win_idx];
  end

  // A late engine handshake or response in the final timer cycle beats the abort.
  assign accept    = (state == S_IDLE) && found && !rst;
  assign timed_out = (timer == TMR_LAST) &&
                     (((state == S_ISSUE) && !eng_req_ready) ||
                      ((state == S_WAIT) && !eng_rsp_valid));

  assign ch_req_ready  = accept ? (NUM_CH'(1) << win_idx) : '0;
  assign ch_rsp_valid  = (state == S_RESP) ? (NUM_CH'(1) << grant_id) : '0;
  assign ch_rsp_data   = rsp_q;
  assign ch_rsp_err    = err_q;
  assign eng_req_valid = (state == S_ISSUE);
  assign eng_op        = op_q;
  assign eng_data      = data_q;
  assign eng_abort     = timed_out;
  assign busy          = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      op_q      <= OP_HASH;
      data_q    <= '0;
      rsp_q     <= '0;
      err_q     <= ERR_OK;
      timer     <= '0;
      err_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            grant_id <= win_idx;
            op_q     <= win_op;
            data_q   <= win_data;
            rsp_q    <= '0;
            timer    <= '0;
            rr_ptr   <= (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
            if (!win_auth) begin
              err_q <= ERR_AUTH;
              state <= S_RESP;
            end else if (win_op == OP_RSVD) begin
              err_q <= ERR_OP;
              state <= S_RESP;
            end else begin
              err_q <= ERR_OK;
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (eng_req_ready) begin
            timer <= '0;
            state <= S_WAIT;
          end else if (timed_out) begin
            err_q <= ERR_TIMEOUT;
            rsp_q <= '0;
            state <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT: begin
          if (eng_rsp_valid) begin
            rsp_q <= eng_rsp_data;
            err_q <= ERR_OK;
            state <= S_RESP;
          end else if (timed_out) begin
            err_q <= ERR_TIMEOUT;
            rsp_q <= '0;
            state <= S_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_RESP: begin
          if ((err_q != ERR_OK) && (err_count != '1)) begin
            err_count <= err_count + 1'b1;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sec_channel_arbiter.sv
// Bench for sec_channel_arbiter: directed and random transactions checked
// against a cycle-schedule reference model of grant order, latency and errors.
module tb_sec_channel_arbiter;
  import sec_arb_pkg::*;

  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 128;
  localparam int TIMEOUT_CYC = 8;
  localparam int CNT_W       = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH-1:0]        ch_auth, ch_req_valid, ch_req_ready, ch_rsp_valid;
  logic [2*NUM_CH-1:0]      ch_req_op;
  logic [DATA_W*NUM_CH-1:0] ch_req_data;
  logic [DATA_W-1:0]        ch_rsp_data, eng_data, eng_rsp_data;
  logic [1:0]               ch_rsp_err, eng_op;
  logic                     eng_req_valid, eng_req_ready, eng_rsp_valid, eng_abort, busy;
  logic [1:0]               grant_id;
  logic [CNT_W-1:0]         err_count;

  int errors = 0;
  int checks = 0;
  int rr_model = 0;
  int cnt_model = 0;
  logic [1:0]        req_op[NUM_CH];
  logic [DATA_W-1:0] req_data[NUM_CH];
  logic [DATA_W-1:0] eng_result;

  sec_channel_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .ch_auth(ch_auth), .ch_req_valid(ch_req_valid),
    .ch_req_ready(ch_req_ready), .ch_req_op(ch_req_op), .ch_req_data(ch_req_data),
    .ch_rsp_valid(ch_rsp_valid), .ch_rsp_data(ch_rsp_data), .ch_rsp_err(ch_rsp_err),
    .eng_req_valid(eng_req_valid), .eng_req_ready(eng_req_ready), .eng_op(eng_op),
    .eng_data(eng_data), .eng_rsp_valid(eng_rsp_valid), .eng_rsp_data(eng_rsp_data),
    .eng_abort(eng_abort), .busy(busy), .grant_id(grant_id), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int pickChannel(input logic [NUM_CH-1:0] vld, input int ptr);
    for (int k = 0; k < NUM_CH; k++) begin
      if (vld[(ptr + k) % NUM_CH]) return (ptr + k) % NUM_CH;
    end
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                             input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic packInputs();
    for (int i = 0; i < NUM_CH; i++) begin
      ch_req_op[2*i +: 2]             = req_op[i];
      ch_req_data[i*DATA_W +: DATA_W] = req_data[i];
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_ready"}, ch_req_ready, '0);
    checkOutput({tag, "_rsp_valid"}, ch_rsp_valid, '0);
    checkOutput({tag, "_eng_valid"}, eng_req_valid, '0);
    checkOutput({tag, "_abort"}, eng_abort, '0);
    checkOutput({tag, "_busy"}, busy, '0);
    checkOutput({tag, "_err_count"}, err_count, cnt_model);
  endtask

  task automatic checkResetOutputs(input string tag);
    cnt_model = 0;
    checkQuiet(tag);
    checkOutput({tag, "_grant_id"}, grant_id, '0);
    checkOutput({tag, "_rsp_err"}, ch_rsp_err, '0);
    checkOutput({tag, "_rsp_data"}, ch_rsp_data, '0);
    checkOutput({tag, "_eng_op"}, eng_op, '0);
    checkOutput({tag, "_eng_data"}, eng_data, '0);
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    ch_req_valid = '0;
    eng_req_ready = 1'b0;
    eng_rsp_valid = 1'b0;
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b0;
    rr_model = 0;
  endtask

  task automatic idleCycles(input int n, input int late_at);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      ch_req_valid  = '0;
      eng_req_ready = 1'b0;
      eng_rsp_valid = (c == late_at);
      eng_rsp_data  = rand128();
      #1;
      checkQuiet("idle");
    end
  endtask

  // One whole transaction; the expected cycle of every strobe comes from the
  // accept/stall/latency arithmetic rather than from tracking DUT state.
  task automatic applyStimulus(input logic [NUM_CH-1:0] vld, input logic [NUM_CH-1:0] auth,
                               input int stall, input int rlat, input bit respond,
                               output int granted);
    int g, resp_cyc, abort_cyc, issue_last, rsp_drive, a;
    bit eng_path;
    logic [1:0] exp_err;
    logic [DATA_W-1:0] exp_data;
    logic [NUM_CH-1:0] oh;
    granted = -1;
    g = pickChannel(vld, rr_model);
    if (g < 0) return;
    rr_model = (g + 1) % NUM_CH;
    oh = NUM_CH'(1) << g;
    abort_cyc = -1;
    rsp_drive = -1;
    issue_last = 0;
    eng_path = 1'b0;
    if (!auth[g]) begin
      exp_err = ERR_AUTH; resp_cyc = 1;
    end else if (req_op[g] == 2'b11) begin
      exp_err = ERR_OP; resp_cyc = 1;
    end else begin
      eng_path = 1'b1;
      if (stall >= TIMEOUT_CYC) begin
        issue_last = TIMEOUT_CYC;
        abort_cyc  = TIMEOUT_CYC;
        resp_cyc   = TIMEOUT_CYC + 1;
        exp_err    = ERR_TIMEOUT;
      end else begin
        a = stall + 1;
        issue_last = a;
        if (respond) rsp_drive = a + rlat;
        if (respond && rlat <= TIMEOUT_CYC) begin
          resp_cyc = a + rlat + 1;
          exp_err  = ERR_OK;
        end else begin
          abort_cyc = a + TIMEOUT_CYC;
          resp_cyc  = abort_cyc + 1;
          exp_err   = ERR_TIMEOUT;
        end
      end
    end
    exp_data = (exp_err == ERR_OK) ? eng_result : '0;
    for (int c = 0; c <= resp_cyc; c++) begin
      @(negedge clk);
      packInputs();
      ch_auth       = (c == 0) ? auth : NUM_CH'($urandom);
      ch_req_valid  = (c == 0) ? vld : (vld & ~oh);
      eng_req_ready = eng_path && (c == stall + 1);
      eng_rsp_valid = (c == rsp_drive);
      eng_rsp_data  = (c == rsp_drive) ? eng_result : rand128();
      #1;
      checkOutput("ready", ch_req_ready, (c == 0) ? oh : '0);
      checkOutput("eng_valid", eng_req_valid, eng_path && c >= 1 && c <= issue_last);
      checkOutput("abort", eng_abort, c == abort_cyc);
      checkOutput("rsp_valid", ch_rsp_valid, (c == resp_cyc) ? oh : '0);
      checkOutput("busy", busy, c >= 1);
      checkOutput("err_count", err_count, cnt_model);
      if (eng_path && c == 1) begin
        checkOutput("eng_op", eng_op, req_op[g]);
        checkOutput("eng_data", eng_data, req_data[g]);
      end
      if (c == resp_cyc) begin
        checkOutput("rsp_err", ch_rsp_err, exp_err);
        checkOutput("rsp_data", ch_rsp_data, exp_data);
        checkOutput("grant_id", grant_id, g);
        granted = int'(grant_id);
      end
    end
    if (exp_err != ERR_OK && cnt_model < (1 << CNT_W) - 1) cnt_model++;
  endtask

  initial begin
    int g;
    int ch;
    int exp_order[5];
    logic [NUM_CH-1:0] vld, auth;

    rst = 1'b0;
    ch_auth = '0;
    ch_req_valid = '0;
    eng_req_ready = 1'b0;
    eng_rsp_valid = 1'b0;
    eng_rsp_data = '0;
    eng_result = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req_op[i] = OP_HASH;
      req_data[i] = '0;
    end
    packInputs();
    #2;
    doReset();

    $display("[TB] single hash on ch0");
    req_data[0] = {16{8'hA5}};
    req_op[0] = OP_HASH;
    eng_result = 128'h1234;
    applyStimulus(4'b0001, 4'b1111, 0, 4, 1'b1, g);
    checkOutput("hash_grant", g, 0);

    $display("[TB] all channels continuous");
    doReset();
    exp_order = '{0, 1, 2, 3, 0};
    for (int i = 0; i < NUM_CH; i++) begin
      req_op[i] = OP_ENC;
      req_data[i] = rand128();
    end
    for (int t = 0; t < 5; t++) begin
      eng_result = rand128();
      applyStimulus(4'b1111, 4'b1111, 0, 2, 1'b1, g);
      checkOutput("rr_order", g, exp_order[t]);
    end

    $display("[TB] auth failure on ch1");
    req_op[1] = OP_ENC;
    applyStimulus(4'b0010, 4'b1101, 0, 1, 1'b1, g);
    idleCycles(1, -1);
    checkOutput("auth_err_count", err_count, 1);

    $display("[TB] engine timeout then late response");
    req_op[3] = OP_HASH;
    applyStimulus(4'b1000, 4'b1111, 0, 1, 1'b0, g);
    idleCycles(4, 1);
    checkOutput("timeout_err_count", err_count, 2);

    $display("[TB] reserved op and counter saturation");
    req_op[2] = OP_RSVD;
    applyStimulus(4'b0100, 4'b1111, 0, 1, 1'b1, g);
    for (int n = 0; n < (1 << CNT_W) + 2; n++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      vld = NUM_CH'(1) << ch;
      if ($urandom_range(0, 1) == 0) begin
        auth = ~vld;
        req_op[ch] = 2'($urandom_range(0, 3));
      end else begin
        auth = '1;
        req_op[ch] = OP_RSVD;
      end
      applyStimulus(vld, auth, 0, 1, 1'b1, g);
    end
    idleCycles(1, -1);
    checkOutput("err_count_sat", err_count, 4'hF);

    $display("[TB] random traffic");
    doReset();
    for (int t = 0; t < 40; t++) begin
      vld = NUM_CH'($urandom_range(1, (1 << NUM_CH) - 1));
      auth = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '1;
      for (int i = 0; i < NUM_CH; i++) begin
        req_op[i] = ($urandom_range(0, 5) == 0) ? OP_RSVD : 2'($urandom_range(0, 2));
        req_data[i] = rand128();
      end
      eng_result = rand128();
      applyStimulus(vld, auth,
                    ($urandom_range(0, 9) == 0) ? TIMEOUT_CYC : $urandom_range(0, 3),
                    $urandom_range(1, TIMEOUT_CYC + 1),
                    $urandom_range(0, 5) != 0, g);
      if ($urandom_range(0, 3) == 0) idleCycles(1, -1);
    end

    $display("[TB] reset during WAIT");
    idleCycles(1, -1);
    ch_auth = '1;
    req_op[2] = OP_ENC;
    req_data[2] = rand128();
    packInputs();
    @(negedge clk);
    ch_req_valid = 4'b0100;
    #1;
    checkOutput("mid_ready", ch_req_ready, 4'b0100);
    @(negedge clk);
    ch_req_valid = '0;
    eng_req_ready = 1'b1;
    #1;
    checkOutput("mid_issue", eng_req_valid, 1'b1);
    @(negedge clk);
    eng_req_ready = 1'b0;
    #1;
    checkOutput("mid_wait_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetOutputs("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    rr_model = 0;
    idleCycles(3, 0);
    req_op[0] = OP_HASH;
    req_op[3] = OP_HASH;
    eng_result = rand128();
    applyStimulus(4'b1001, 4'b1111, 0, 2, 1'b1, g);
    checkOutput("post_reset_grant", g, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
